// File: rtl/num_entry_fsm.sv
// PS/2 numeric-entry controller: collects decimal keystrokes, edits them, and commits a clamped binary value.
// Define NUM_ENTRY_NUMPAD_EN to also accept keypad digits and keypad Enter (E0 5A).
module num_entry_fsm #(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned VAL_W     = 10,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 999,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Enable,
    input  logic [7:0]            data,
    input  logic                  data_en,
    output logic [VAL_W-1:0]      Value,
    output logic                  Commit,
    output logic                  Clamped,
    output logic [4*DIGITS-1:0]   Live_bcd,
    output logic [2:0]            Count,
    output logic                  Editing,
    output logic                  Err
);

    localparam int unsigned BIN_W = VAL_W + 4;
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [2:0]       DIGITS_C = 3'(DIGITS);
    localparam logic [BIN_W-1:0] MIN_B    = BIN_W'(MIN_VAL);
    localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT} state_e;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   buf_q, buf_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic               commit_q, commit_d;
    logic               clamped_q, clamped_d;
    logic               brk_q, brk_d;
    logic               ext_q, ext_d;

    logic               make, ext_enter;
    logic               key_digit, key_enter, key_bksp, key_esc;
    logic [3:0]         digit;
    logic [BIN_W-1:0]   bin, clamp_v;
    logic               clamp_hit;

    // Break/extended prefix tracking; runs regardless of Enable.
    always_comb begin
        brk_d     = brk_q;
        ext_d     = ext_q;
        make      = 1'b0;
        ext_enter = 1'b0;
        if (data_en) begin
            if (data == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end else if (data == 8'hE0) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
`ifdef NUM_ENTRY_NUMPAD_EN
                ext_enter = (data == 8'h5A);
`endif
            end else begin
                make = 1'b1;
            end
        end
    end

    always_comb begin
        key_digit = 1'b0;
        digit     = 4'd0;
        if (make) begin
            key_digit = 1'b1;
            case (data)
                8'h45: digit = 4'd0;
                8'h16: digit = 4'd1;
                8'h1E: digit = 4'd2;
                8'h26: digit = 4'd3;
                8'h25: digit = 4'd4;
                8'h2E: digit = 4'd5;
                8'h36: digit = 4'd6;
                8'h3D: digit = 4'd7;
                8'h3E: digit = 4'd8;
                8'h46: digit = 4'd9;
`ifdef NUM_ENTRY_NUMPAD_EN
                8'h70: digit = 4'd0;
                8'h69: digit = 4'd1;
                8'h72: digit = 4'd2;
                8'h7A: digit = 4'd3;
                8'h6B: digit = 4'd4;
                8'h73: digit = 4'd5;
                8'h74: digit = 4'd6;
                8'h6C: digit = 4'd7;
                8'h75: digit = 4'd8;
                8'h7D: digit = 4'd9;
`endif
                default: key_digit = 1'b0;
            endcase
        end
        key_enter = (make && data == 8'h5A) || ext_enter;
        key_bksp  = make && data == 8'h66;
        key_esc   = make && data == 8'h76;
    end

    // Most significant digit first: bin = bin*10 + d, wide enough that nothing truncates before the clamp.
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            bin = BIN_W'(bin * BIN_W'(10)) + BIN_W'(buf_q[4*(DIGITS-1-i) +: 4]);
        end
        clamp_hit = 1'b1;
        if (bin > MAX_B) begin
            clamp_v = MAX_B;
        end else if (bin < MIN_B) begin
            clamp_v = MIN_B;
        end else begin
            clamp_v   = bin;
            clamp_hit = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        value_d   = value_q;
        commit_d  = 1'b0;
        clamped_d = 1'b0;
        if (!Enable) begin
            state_d = S_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_digit) begin
                        buf_d   = BCD_W'(digit);
                        cnt_d   = 3'd1;
                        state_d = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (key_digit) begin
                        if (cnt_q < DIGITS_C) begin
                            buf_d = BCD_W'({buf_q, digit});
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_bksp) begin
                        buf_d = buf_q >> 4;
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q == 3'd1) state_d = S_IDLE;
                    end else if (key_esc) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                    end else if (key_enter) begin
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    value_d   = clamp_v[VAL_W-1:0];
                    commit_d  = 1'b1;
                    clamped_d = clamp_hit;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            value_q   <= VAL_W'(RESET_VAL);
            commit_q  <= 1'b0;
            clamped_q <= 1'b0;
            brk_q     <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            value_q   <= value_d;
            commit_q  <= commit_d;
            clamped_q <= clamped_d;
            brk_q     <= brk_d;
            ext_q     <= ext_d;
        end
    end

    assign Value    = value_q;
    assign Commit   = commit_q;
    assign Clamped  = clamped_q;
    assign Live_bcd = buf_q;
    assign Count    = cnt_q;
    assign Editing  = (state_q == S_ENTRY);
    assign Err      = err_q;

endmodule

// File: tb/tb_num_entry_fsm.sv
// Bench for num_entry_fsm: two instances (default range, and a 5..300 clamp) driven by one PS/2 byte stream.
module tb_num_entry_fsm;

    localparam int DIG = 3;
`ifdef NUM_ENTRY_NUMPAD_EN
    localparam bit NUMPAD = 1'b1;
`else
    localparam bit NUMPAD = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        nReset, Enable, data_en;
    logic [7:0]  data;

    logic [9:0]  value_a, value_b;
    logic        commit_a, commit_b, clamped_a, clamped_b;
    logic [11:0] bcd_a, bcd_b;
    logic [2:0]  count_a, count_b;
    logic        editing_a, editing_b, err_a, err_b;

    always #5 Clock = ~Clock;

    num_entry_fsm #(.DIGITS(3), .VAL_W(10), .MIN_VAL(0), .MAX_VAL(999), .RESET_VAL(0)) dut_a (
        .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data), .data_en(data_en),
        .Value(value_a), .Commit(commit_a), .Clamped(clamped_a), .Live_bcd(bcd_a),
        .Count(count_a), .Editing(editing_a), .Err(err_a));

    num_entry_fsm #(.DIGITS(3), .VAL_W(10), .MIN_VAL(5), .MAX_VAL(300), .RESET_VAL(7)) dut_b (
        .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data), .data_en(data_en),
        .Value(value_b), .Commit(commit_b), .Clamped(clamped_b), .Live_bcd(bcd_b),
        .Count(count_b), .Editing(editing_b), .Err(err_b));

    int n_cmp = 0;
    int n_bad = 0;
    int commits_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model: the entry is held as an integer plus a digit count; keys are classified by table lookup.
    bit m_edit, m_pend, m_err, m_com, m_cla, m_clb, m_brk, m_ext;
    int m_num, m_cnt, m_val_a, m_val_b, m_key;

    function automatic int decode(input logic [7:0] b);
        logic [7:0] main_row [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] keypad [10]   = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
        for (int i = 0; i < 10; i++) begin
            if (b == main_row[i]) return i;
            if (NUMPAD && b == keypad[i]) return i;
        end
        if (b == 8'h5A) return 10;
        if (b == 8'h66) return 11;
        if (b == 8'h76) return 12;
        return -1;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

    function automatic int to_bcd(input int n);
        int r = 0;
        for (int i = 0; i < DIG; i++) begin
            r += (n % 10) << (4 * i);
            n = n / 10;
        end
        return r;
    endfunction

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            m_edit = 0; m_pend = 0; m_err = 0; m_com = 0; m_cla = 0; m_clb = 0;
            m_brk = 0; m_ext = 0; m_num = 0; m_cnt = 0; m_val_a = 0; m_val_b = 7;
        end else begin
            m_key = -1;
            m_com = 0; m_cla = 0; m_clb = 0;
            if (data_en) begin
                if (data == 8'hF0) m_brk = 1;
                else if (m_brk) begin m_brk = 0; m_ext = 0; end
                else if (data == 8'hE0) m_ext = 1;
                else if (m_ext) begin
                    m_ext = 0;
                    if (NUMPAD && data == 8'h5A) m_key = 10;
                end else m_key = decode(data);
            end
            if (!Enable) begin
                m_edit = 0; m_pend = 0; m_num = 0; m_cnt = 0; m_err = 0;
            end else if (m_pend) begin
                m_pend = 0;
                m_com = 1;
                m_val_a = clamp(m_num, 0, 999);
                m_val_b = clamp(m_num, 5, 300);
                m_cla = (m_val_a != m_num);
                m_clb = (m_val_b != m_num);
                m_cnt = 0;
                m_err = 0;
            end else if (m_key >= 0 && m_key <= 9) begin
                if (!m_edit) begin
                    m_num = m_key; m_cnt = 1; m_edit = 1;
                end else if (m_cnt < DIG) begin
                    m_num = m_num * 10 + m_key; m_cnt++;
                end else m_err = 1;
            end else if (m_edit) begin
                case (m_key)
                    10: begin m_edit = 0; m_pend = 1; end
                    11: begin m_num = m_num / 10; m_cnt--; if (m_cnt == 0) m_edit = 0; end
                    12: begin m_num = 0; m_cnt = 0; m_edit = 0; m_err = 0; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge Clock) begin
        chk("value_a", value_a, m_val_a);
        chk("value_b", value_b, m_val_b);
        chk("commit_a", commit_a, m_com);
        chk("commit_b", commit_b, m_com);
        chk("clamped_a", clamped_a, m_cla);
        chk("clamped_b", clamped_b, m_clb);
        chk("bcd_a", bcd_a, to_bcd(m_num));
        chk("bcd_b", bcd_b, to_bcd(m_num));
        chk("count_a", count_a, m_cnt);
        chk("count_b", count_b, m_cnt);
        chk("editing_a", editing_a, m_edit);
        chk("err_a", err_a, m_err);
        if (commit_a) commits_seen++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge Clock);
        data = b;
        data_en = 1'b1;
        @(negedge Clock);
        data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        nReset = 1'b0; Enable = 1'b1; data = 8'h00; data_en = 1'b0;
        idle(3);
        chk("rst_value_a", value_a, 0);
        chk("rst_value_b", value_b, 7);
        chk("rst_count", count_a, 0);
        nReset = 1'b1;
        idle(2);

        // 12 with break codes interleaved
        send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0); send(8'h1E);
        chk("t1_bcd", bcd_a, 12'h012);
        send(8'h5A); idle(2);
        chk("t1_value_a", value_a, 12);
        chk("t1_value_b", value_b, 12);
        chk("t1_commits", commits_seen, 1);

        // overflow digit rejected
        send(8'h26); send(8'h25); send(8'h2E); send(8'h36);
        chk("t2_count", count_a, 3);
        chk("t2_err", err_a, 1);
        chk("t2_bcd", bcd_a, 12'h345);
        send(8'h5A); idle(2);
        chk("t2_value_a", value_a, 345);
        chk("t2_value_b", value_b, 300);
        chk("t2_err_clr", err_a, 0);

        send(8'h46); send(8'h46); send(8'h46); send(8'h5A); idle(2);
        chk("t3_value_a", value_a, 999);
        chk("t3_value_b", value_b, 300);
        send(8'h16); send(8'h5A); idle(2);
        chk("t3_min_a", value_a, 1);
        chk("t3_min_b", value_b, 5);

        // backspace to empty, then Enter does nothing
        send(8'h16); chk("t4_cnt1", count_a, 1);
        send(8'h1E); chk("t4_cnt2", count_a, 2);
        send(8'h66); chk("t4_cnt3", count_a, 1);
        send(8'h66); chk("t4_cnt4", count_a, 0);
        chk("t4_editing", editing_a, 0);
        send(8'h5A); idle(2);
        chk("t4_value", value_a, 1);
        chk("t4_commits", commits_seen, 4);

        // Enable low mid-entry, ESC mid-entry, Enable low during COMMIT, make byte while disabled
        send(8'h16); send(8'h1E);
        Enable = 1'b0; idle(1); Enable = 1'b1;
        chk("t5_cnt_dis", count_a, 0);
        send(8'h16); send(8'h1E); send(8'h76);
        chk("t5_cnt_esc", count_a, 0);
        chk("t5_val_esc", value_a, 1);
        send(8'h16); send(8'h5A);
        Enable = 1'b0; idle(1); Enable = 1'b1; idle(2);
        chk("t5_no_commit", commits_seen, 4);
        @(negedge Clock);
        Enable = 1'b0; data = 8'h26; data_en = 1'b1;
        @(negedge Clock);
        Enable = 1'b1; data_en = 1'b0;
        chk("t5_dropped", count_a, 0);

        // Extended-prefix handling
        send(8'hE0); send(8'hF0); send(8'h16);
        chk("t6_e0f0", count_a, 0);
        send(8'hE0); send(8'h16);
        chk("t6_e0", count_a, 0);
        send(8'h16); send(8'hE0); send(8'h5A); idle(2);
        send(8'h70);
`ifdef NUM_ENTRY_NUMPAD_EN
        chk("t6_kp_commits", commits_seen, 5);
        chk("t6_kp_digit", count_a, 1);
`else
        chk("t6_kp_commits", commits_seen, 4);
        chk("t6_kp_ignored", count_a, 1);
`endif
        send(8'h76);

        // asynchronous reset mid-entry
        send(8'h26); send(8'h25);
        nReset = 1'b0;
        idle(1);
        chk("t6_rst_value_a", value_a, 0);
        chk("t6_rst_value_b", value_b, 7);
        chk("t6_rst_count", count_a, 0);
        chk("t6_rst_bcd", bcd_a, 0);
        nReset = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
